// File: rtl/store_lane_unit.sv
// Store-path lane steering: turns one byte/word store into one or two
// little-endian memory writes with byte enables; unaligned words are split.
module store_lane_unit #(
    parameter int WORD = 16,
    parameter int ADDR = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ADDR-1:0] req_addr,
    input  logic [WORD-1:0] req_data,
    input  logic            req_byte,
    output logic            mem_wr,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    output logic [1:0]      mem_be,
    input  logic            mem_ack,
    output logic            done
);
    localparam int HALF = WORD / 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR1  = 2'd1;
    localparam logic [1:0] S_WR2  = 2'd2;
    localparam logic [ADDR-1:0] ADDR_ONE = {{(ADDR-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [ADDR-1:0] addr_q;
    logic [HALF-1:0] hi_q;
    logic            split_q;

    logic [WORD-1:0] first_wdata;
    logic [1:0]      first_be;
    logic            req_split;

    // Request handshake: a store is taken on any rising edge where
    // req_valid && req_ready. Memory handshake: the write fields hold
    // until an edge with mem_wr && mem_ack, which retires that write.
    assign req_ready = (state == S_IDLE);
    assign req_split = !req_byte && req_addr[0];

    // Byte stores and the first half of a split word replicate the low
    // lane so the enabled lane always carries the right byte.
    always_comb begin
        first_wdata = {req_data[HALF-1:0], req_data[HALF-1:0]};
        first_be    = 2'b01;
        if (!req_byte && !req_addr[0]) begin
            first_wdata = req_data;
            first_be    = 2'b11;
        end else if (req_addr[0]) begin
            first_be = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            hi_q      <= '0;
            split_q   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 2'b00;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_wr <= 1'b0;
                    mem_be <= 2'b00;
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        hi_q      <= req_data[WORD-1:HALF];
                        split_q   <= req_split;
                        state     <= S_WR1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= req_addr;
                        mem_wdata <= first_wdata;
                        mem_be    <= first_be;
                    end
                end
                S_WR1: begin
                    if (mem_ack) begin
                        if (split_q) begin
                            state     <= S_WR2;
                            mem_addr  <= addr_q + ADDR_ONE;
                            mem_wdata <= {hi_q, hi_q};
                            mem_be    <= 2'b01;
                        end else begin
                            state  <= S_IDLE;
                            mem_wr <= 1'b0;
                            mem_be <= 2'b00;
                            done   <= 1'b1;
                        end
                    end
                end
                S_WR2: begin
                    if (mem_ack) begin
                        state  <= S_IDLE;
                        mem_wr <= 1'b0;
                        mem_be <= 2'b00;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    mem_wr <= 1'b0;
                    mem_be <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_lane_unit.sv
// Self-checking bench for store_lane_unit: per-cycle trace compared against
// a write-list reference model built from the lane-steering rules.
module tb_store_lane_unit;
    localparam int WORD = 16;
    localparam int ADDR = 16;
    localparam int HALF = WORD / 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [ADDR-1:0] req_addr = '0;
    logic [WORD-1:0] req_data = '0;
    logic            req_byte = 1'b0;
    logic            mem_wr;
    logic [ADDR-1:0] mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic [1:0]      mem_be;
    logic            mem_ack = 1'b0;
    logic            done;

    store_lane_unit #(.WORD(WORD), .ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_byte(req_byte),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR-1:0] a;
        logic [WORD-1:0] d;
        logic [1:0]      be;
    } wr_t;

    typedef struct packed {
        logic            wr;
        logic [ADDR-1:0] a;
        logic [WORD-1:0] d;
        logic [1:0]      be;
        logic            dn;
        logic            rdy;
    } cyc_t;

    int   n_checks = 0;
    int   n_pass = 0;
    wr_t  wr_q[$];
    cyc_t exp_q[$];
    cyc_t obs_q[$];

    function automatic cyc_t sample();
        cyc_t c;
        c = '{wr: mem_wr, a: mem_addr, d: mem_wdata, be: mem_be, dn: done, rdy: req_ready};
        return c;
    endfunction

    // Reference: list of memory writes a store produces, then the per-cycle
    // trace expected when each write is acked after wait_n idle-ack cycles.
    task automatic model_store(input logic [ADDR-1:0] a, input logic [WORD-1:0] d,
                               input logic byt, input int wait_n);
        logic [HALF-1:0] lo;
        logic [HALF-1:0] hi;
        logic [ADDR-1:0] a_next;
        wr_t last;
        lo = d[HALF-1:0];
        hi = d[WORD-1:HALF];
        a_next = a + 16'd1;
        wr_q.delete();
        exp_q.delete();
        if (byt)
            wr_q.push_back('{a: a, d: {lo, lo}, be: (a[0] ? 2'b10 : 2'b01)});
        else if (!a[0])
            wr_q.push_back('{a: a, d: d, be: 2'b11});
        else begin
            wr_q.push_back('{a: a, d: {lo, lo}, be: 2'b10});
            wr_q.push_back('{a: a_next, d: {hi, hi}, be: 2'b01});
        end
        last = wr_q[0];
        foreach (wr_q[k]) begin
            for (int c = 0; c <= wait_n; c++)
                exp_q.push_back('{wr: 1'b1, a: wr_q[k].a, d: wr_q[k].d, be: wr_q[k].be, dn: 1'b0, rdy: 1'b0});
            last = wr_q[k];
        end
        exp_q.push_back('{wr: 1'b0, a: last.a, d: last.d, be: 2'b00, dn: 1'b1, rdy: 1'b1});
        exp_q.push_back('{wr: 1'b0, a: last.a, d: last.d, be: 2'b00, dn: 1'b0, rdy: 1'b1});
    endtask

    // Driver + memory responder; records one sample per cycle from the
    // cycle after acceptance. Called at a negedge with the unit idle.
    task automatic do_store(input logic [ADDR-1:0] a, input logic [WORD-1:0] d,
                            input logic byt, input int wait_n, input bit poke);
        int cnt;
        cyc_t c;
        req_addr  = a;
        req_data  = d;
        req_byte  = byt;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        obs_q.delete();
        cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            c = sample();
            obs_q.push_back(c);
            mem_ack = 1'b0;
            if (c.wr) begin
                if (cnt == wait_n) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            req_valid = poke && c.wr && !mem_ack;
            if (req_valid) begin
                req_addr = ADDR'($urandom);
                req_data = WORD'($urandom);
                req_byte = 1'($urandom);
            end
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t c;
        cyc_t e;
        rst_n = 1'b0;
        #12;
        c = sample();
        e = '{wr: 1'b0, a: '0, d: '0, be: 2'b00, dn: 1'b0, rdy: 1'b1};
        n_checks++;
        if (c !== e)
            $display("FAIL reset_state got %h expected %h", c, e);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [ADDR-1:0] ta[4] = '{16'h0100, 16'h0200, 16'h0201, 16'hFFFF};
        logic [WORD-1:0] td[4] = '{16'hBEEF, 16'h12A5, 16'h12A5, 16'h1234};
        logic            tb[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            model_store(ta[t], td[t], tb[t], 0);
            do_store(ta[t], td[t], tb[t], 0, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL directed%0d cycle %0d got wr=%0b a=%h d=%h be=%b done=%0b rdy=%0b expected wr=%0b a=%h d=%h be=%b done=%0b rdy=%0b",
                             t, i + 1, obs_q[i].wr, obs_q[i].a, obs_q[i].d, obs_q[i].be, obs_q[i].dn, obs_q[i].rdy,
                             exp_q[i].wr, exp_q[i].a, exp_q[i].d, exp_q[i].be, exp_q[i].dn, exp_q[i].rdy);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_wait_states();
        model_store(16'h0300, 16'hC0DE, 1'b0, 3);
        do_store(16'h0300, 16'hC0DE, 1'b0, 3, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL wait_states cycle %0d got %h expected %h", i + 1, obs_q[i], exp_q[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        cyc_t e;
        req_addr = 16'h0400; req_data = 16'hAAAA; req_byte = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        c = sample();
        e = '{wr: 1'b1, a: 16'h0400, d: 16'hAAAA, be: 2'b11, dn: 1'b0, rdy: 1'b0};
        n_checks++;
        if (c !== e) $display("FAIL b2b_first_write got %h expected %h", c, e);
        else n_pass++;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        c = sample();
        e = '{wr: 1'b0, a: 16'h0400, d: 16'hAAAA, be: 2'b00, dn: 1'b1, rdy: 1'b1};
        n_checks++;
        if (c !== e) $display("FAIL b2b_done_cycle got %h expected %h", c, e);
        else n_pass++;
        req_addr = 16'h0403; req_data = 16'h005A; req_byte = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        c = sample();
        e = '{wr: 1'b1, a: 16'h0403, d: 16'h5A5A, be: 2'b10, dn: 1'b0, rdy: 1'b0};
        n_checks++;
        if (c !== e) $display("FAIL b2b_second_write got %h expected %h", c, e);
        else n_pass++;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        c = sample();
        e = '{wr: 1'b0, a: 16'h0403, d: 16'h5A5A, be: 2'b00, dn: 1'b1, rdy: 1'b1};
        n_checks++;
        if (c !== e) $display("FAIL b2b_second_done got %h expected %h", c, e);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_split();
        cyc_t c;
        cyc_t e;
        int done_seen;
        req_addr = 16'h0501; req_data = 16'h9876; req_byte = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        c = sample();
        e = '{wr: 1'b1, a: 16'h0502, d: 16'h9898, be: 2'b01, dn: 1'b0, rdy: 1'b0};
        n_checks++;
        if (c !== e) $display("FAIL mid_split_wr2 got %h expected %h", c, e);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        c = sample();
        e = '{wr: 1'b0, a: '0, d: '0, be: 2'b00, dn: 1'b0, rdy: 1'b1};
        n_checks++;
        if (c !== e) $display("FAIL mid_split_reset got %h expected %h", c, e);
        else n_pass++;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) done_seen++;
        n_checks++;
        if (done_seen !== 0) $display("FAIL mid_split_no_done got %0d pulses expected 0", done_seen);
        else n_pass++;
        model_store(16'h0601, 16'h00C3, 1'b1, 1);
        do_store(16'h0601, 16'h00C3, 1'b1, 1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL after_reset cycle %0d got %h expected %h", i + 1, obs_q[i], exp_q[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        logic [ADDR-1:0] a;
        logic [WORD-1:0] d;
        logic            byt;
        int              w;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: a = 16'h0000;
                default: a = ADDR'($urandom);
            endcase
            d   = WORD'($urandom);
            byt = 1'($urandom_range(0, 1));
            w   = $urandom_range(0, 3);
            model_store(a, d, byt, w);
            do_store(a, d, byt, w, 1'($urandom_range(0, 1)));
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL random%0d cycle %0d got %h expected %h", t, i + 1, obs_q[i], exp_q[i]);
                else
                    n_pass++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_split();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
